freq_link_ctrl: RTL
===================

# freq_link_ctrl

Half-duplex link scheduler for the frequency encoder/decoder pair. Serializes a transmit byte into timed bit slots for the encoder (enable plus data bit) and keeps the decoder disabled while transmitting, so the channel never hears its own output. Outside transmit it keeps the decoder listening and assembles decoded bit strobes into received bytes, with a timeout. Sits between the top-level I/O logic and the encoder/decoder instances.

## Interface
- `BIT_CYCLES`, default 16: cycles `enc_en` is held high per bit slot; must be ≥1.
- `GAP_CYCLES`, default 4: idle cycles after each bit slot; 0 means no gap.
- `RX_TIMEOUT`, default 64: cycles without a decoder strobe before an RX byte is abandoned; must be ≥2.

- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `tx_valid`, in, 1: transmit byte offered.
- `tx_data`, in, 8: byte to transmit, sent LSB first.
- `tx_ready`, out, 1: combinational; `(state==IDLE) && !dec_bit_valid`.
- `tx_done`, out, 1: one-cycle pulse when the last gap of a byte ends.
- `enc_en`, out, 1: encoder enable; high only during bit slots.
- `enc_data`, out, 1: current bit to the encoder; 0 whenever `enc_en`=0.
- `dec_en`, out, 1: decoder enable; high in IDLE and RX.
- `dec_bit_valid`, in, 1: decoder strobe, one cycle per decoded bit.
- `dec_bit`, in, 1: decoded bit value; qualified by `dec_bit_valid`.
- `rx_data`, out, 8: last completed received byte, LSB received first.
- `rx_valid`, out, 1: one-cycle pulse when `rx_data` updates.
- `rx_err`, out, 1: one-cycle pulse on RX timeout.
- `busy`, out, 1: high when state ≠ IDLE.

## Operation
- **States:** IDLE, TX_BIT, TX_GAP, RX. Reset state is IDLE.
- **Reset values:** `enc_en`, `enc_data`, `tx_done`, `rx_valid`, `rx_err`, `busy` = 0; `rx_data` = 0x00; `dec_en` = 1. `tx_ready` = 1 during reset (follows state); no transfer completes while `rst_n` = 0.
- **IDLE → RX:** taken on `dec_bit_valid`. RX has priority over a simultaneous `tx_valid`, and `tx_ready` is low that cycle. Actions:
  - Shift register bit 0 is set from `dec_bit`.
  - Bit count is set to 1.
  - Timeout timer is cleared.
- **IDLE → TX_BIT:** taken on `tx_valid && tx_ready`. Actions:
  - `tx_data` is latched.
  - Bit index is set to 0.
  - Slot counter is cleared.
- **TX_BIT:**
  - `enc_en`=1, `enc_data`=latched[index], `dec_en`=0.
  - After `BIT_CYCLES` cycles, go to TX_GAP. If `GAP_CYCLES`=0, go directly to the next TX_BIT, or to IDLE after index 7.
- **TX_GAP:**
  - `enc_en`=0, `dec_en`=0.
  - After `GAP_CYCLES` cycles: if index = 7, go to IDLE and pulse `tx_done`; otherwise increment the index and go to TX_BIT.
- **TX period:** `dec_bit_valid` is ignored for the whole of TX_BIT and TX_GAP.
- **RX:**
  - `dec_en`=1. The timer increments each cycle and clears on every strobe.
  - Each strobe stores `dec_bit` at position = count, then increments the count.
  - On the 8th bit: `rx_data` is updated, `rx_valid` is pulsed, and the state returns to IDLE.
  - When the timer reaches `RX_TIMEOUT`: `rx_err` is pulsed, the partial byte is discarded (`rx_data` unchanged), and the state returns to IDLE.
  - If a strobe and the timeout land in the same cycle, the strobe wins.
- **Counter width:** counters are sized `$clog2` of max(`BIT_CYCLES`, `GAP_CYCLES`, `RX_TIMEOUT`)+1 and never wrap within a state.
- **Mid-operation reset:** `rst_n` low aborts any state immediately to IDLE with reset values. A partial TX byte is not resumed; a partial RX byte is lost.

## Timing
- **TX acceptance:** at edge N. `enc_en` rises after edge N (cycle N+1) with `enc_data`=bit0.
- **TX byte length:** occupies exactly 8×(`BIT_CYCLES`+`GAP_CYCLES`) cycles.
- **`tx_done`:** high in the final gap cycle's successor, together with `tx_ready` returning high.
- **Back-to-back TX:** a new byte is accepted the same cycle `tx_done` is high, so `enc_en` resumes one cycle later.
- **`rx_valid` / `rx_data`:** both registered; they appear the cycle after the 8th strobe.
- **`rx_err`:** appears the cycle after the timer reaches `RX_TIMEOUT`.
- **`dec_en` after TX:** rises the cycle after leaving TX_GAP of bit 7.

## Test plan
- **Single TX:** defaults, `tx_data`=0xA5 → `enc_en` shows 8 pulses of 16 cycles separated by 4-cycle gaps; `enc_data` = 1,0,1,0,0,1,0,1; `dec_en`=0 throughout; `tx_done` one pulse at cycle 160 after acceptance.
- **Back-to-back TX:** 0x01 then 0xFF with `tx_valid` held → no idle cycle beyond one; second byte's bits are all 1; two `tx_done` pulses.
- **RX byte:** strobes every 20 cycles carrying 0x3C LSB first → `rx_data`=0x3C and `rx_valid` pulse one cycle after the 8th strobe; `rx_err`=0.
- **RX timeout:** 3 strobes, then silence → `rx_err` pulse 64 cycles after the 3rd strobe; `rx_data` keeps its prior value; `tx_ready` = 1 next cycle.
- **Collision:** `tx_valid` and `dec_bit_valid` asserted in the same IDLE cycle → RX entered, `tx_ready`=0, TX byte accepted only after RX completes; strobes during TX are ignored.
- **Reset mid-TX:** drop `rst_n` during bit 3 → `enc_en`=0 immediately, `busy`=0, `tx_done` never pulses; after release, a fresh 0x5A transmits correctly.

Source files
------------

// File: rtl/freq_link_ctrl.sv
// Half-duplex link scheduler: serializes TX bytes into timed encoder slots and
// assembles decoder strobes into RX bytes, keeping the decoder deaf during TX.
module freq_link_ctrl #(
  parameter int BIT_CYCLES = 16,
  parameter int GAP_CYCLES = 4,
  parameter int RX_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       enc_en,
  output logic       enc_data,
  output logic       dec_en,
  input  logic       dec_bit_valid,
  input  logic       dec_bit,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy
);

  localparam int MAX_BG  = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_BG > RX_TIMEOUT) ? MAX_BG : RX_TIMEOUT;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam logic [CW-1:0] RX_LAST  = CW'(RX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TX_BIT = 2'd1,
    TX_GAP = 2'd2,
    RX     = 2'd3
  } state_t;

  state_t        state;
  logic [7:0]    tx_shift;
  logic [2:0]    bit_idx;
  logic [CW-1:0] slot_cnt;
  logic [7:0]    rx_shift;
  logic [2:0]    rx_cnt;
  logic [CW-1:0] rx_timer;

  // An incoming strobe claims the channel before any pending transmit.
  assign tx_ready = (state == IDLE) && !dec_bit_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_shift <= '0;
      bit_idx  <= '0;
      slot_cnt <= '0;
      rx_shift <= '0;
      rx_cnt   <= '0;
      rx_timer <= '0;
      tx_done  <= 1'b0;
      enc_en   <= 1'b0;
      enc_data <= 1'b0;
      dec_en   <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (dec_bit_valid) begin
            state       <= RX;
            rx_shift[0] <= dec_bit;
            rx_cnt      <= 3'd1;
            rx_timer    <= '0;
            busy        <= 1'b1;
          end else if (tx_valid && tx_ready) begin
            state    <= TX_BIT;
            tx_shift <= tx_data;
            bit_idx  <= 3'd0;
            slot_cnt <= '0;
            enc_en   <= 1'b1;
            enc_data <= tx_data[0];
            dec_en   <= 1'b0;
            busy     <= 1'b1;
          end
        end

        // With no gap configured, bit slots run back to back inside TX_BIT.
        TX_BIT: begin
          if (slot_cnt == BIT_LAST) begin
            slot_cnt <= '0;
            if (GAP_CYCLES != 0) begin
              state    <= TX_GAP;
              enc_en   <= 1'b0;
              enc_data <= 1'b0;
            end else if (bit_idx == 3'd7) begin
              state    <= IDLE;
              enc_en   <= 1'b0;
              enc_data <= 1'b0;
              dec_en   <= 1'b1;
              busy     <= 1'b0;
              tx_done  <= 1'b1;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              enc_data <= tx_shift[bit_idx + 3'd1];
            end
          end else begin
            slot_cnt <= slot_cnt + CW'(1);
          end
        end

        TX_GAP: begin
          if (slot_cnt == GAP_LAST) begin
            slot_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= IDLE;
              dec_en  <= 1'b1;
              busy    <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              state    <= TX_BIT;
              bit_idx  <= bit_idx + 3'd1;
              enc_en   <= 1'b1;
              enc_data <= tx_shift[bit_idx + 3'd1];
            end
          end else begin
            slot_cnt <= slot_cnt + CW'(1);
          end
        end

        // A strobe landing on the timeout cycle still counts as a bit.
        RX: begin
          if (dec_bit_valid) begin
            rx_timer         <= '0;
            rx_shift[rx_cnt] <= dec_bit;
            if (rx_cnt == 3'd7) begin
              rx_data  <= {dec_bit, rx_shift[6:0]};
              rx_valid <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              rx_cnt <= rx_cnt + 3'd1;
            end
          end else if (rx_timer == RX_LAST) begin
            rx_err <= 1'b1;
            state  <= IDLE;
            busy   <= 1'b0;
          end else begin
            rx_timer <= rx_timer + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
